// File: rtl/bus_decode_pkg.sv
// Shared types and constants for the table-driven bus region decoder.
//   bus_state_e : bus-cycle FSM states
//   region_t    : one region table entry (enable, inclusive start/end, wait states)
//   PCB_*       : profile indices used by the loader when selecting a region table
//   region_hit  : single-entry match test used by the priority encoder
package bus_decode_pkg;

  // Region records are stored at a fixed maximum width so one record type serves
  // both the 24-bit 68000 instance and the 16-bit Z80 instance. Narrower instances
  // zero-extend on write, so the unused upper bits stay constant zero.
  localparam int RGN_ADDR_MAX = 32;
  localparam int RGN_WAIT_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_WAIT     = 3'd2,
    ST_ACK      = 3'd3,
    ST_BERR_CNT = 3'd4,
    ST_BERR     = 3'd5
  } bus_state_e;

  typedef struct packed {
    logic                    en;
    logic [RGN_ADDR_MAX-1:0] rgn_start;
    logic [RGN_ADDR_MAX-1:0] rgn_end;
    logic [RGN_WAIT_MAX-1:0] rgn_wait;
  } region_t;

  localparam region_t REGION_CLEAR = '0;

  localparam int PCB_TERRA_CRESTA = 0;
  localparam int PCB_AMAZON       = 1;
  localparam int PCB_HOREKID      = 2;
  localparam int PCB_AMAZONT      = 3;
  localparam int PCB_HOREKIDB2    = 4;

  // Unsigned inclusive range test; an entry with start > end can never match.
  function automatic logic region_hit(input region_t r, input logic [RGN_ADDR_MAX-1:0] a);
    return r.en && (a >= r.rgn_start) && (a <= r.rgn_end);
  endfunction

endpackage

// File: rtl/region_match.sv
// Combinational priority encoder over the region table.
// Ports:
//   i_addr    [ADDR_W]      bus address to classify
//   i_table   [N_REGIONS]   region entries
//   o_hit                   some enabled entry contains i_addr
//   o_hit_idx [IDX_W]       lowest matching index (0 when no hit)
//   o_onehot  [N_REGIONS]   one-hot of o_hit_idx, all zero when no hit
module region_match
  import bus_decode_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int N_REGIONS = 16,
  parameter int IDX_W     = $clog2(N_REGIONS)
) (
  input  logic [ADDR_W-1:0]    i_addr,
  input  region_t              i_table [N_REGIONS],
  output logic                 o_hit,
  output logic [IDX_W-1:0]     o_hit_idx,
  output logic [N_REGIONS-1:0] o_onehot
);

  logic [RGN_ADDR_MAX-1:0] w_addr_ext;

  assign w_addr_ext = RGN_ADDR_MAX'(i_addr);

  // Scan from the highest index down so the lowest matching index is the last
  // assignment and wins; the vector is rebuilt on every hit, keeping it one-hot.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_idx = '0;
    o_onehot  = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (region_hit(i_table[i], w_addr_ext)) begin
        o_hit       = 1'b1;
        o_hit_idx   = IDX_W'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_region_decoder.sv
// Table-driven bus decoder with per-region wait states and bus-error timeout.
// Ports:
//   i_clk, i_reset              core clock, synchronous active-high reset
//   i_cfg_we/idx/en/start/end/wait   region table write port
//   i_addr, i_as_n              bus address and active-low address strobe
//   o_cs [N_REGIONS]            registered one-hot chip selects
//   o_hit, o_hit_idx            a region is selected / which one
//   o_dtack_n, o_berr_n         active-low acknowledge / bus error
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no bus cycle; waiting for the strobe to be sampled low
// DECODE   | table lookup on the live address, result latched on exit
// WAIT     | region wait states counting down
// ACK      | dtack_n asserted until the strobe is released
// BERR_CNT | unmapped access, timing out towards bus error
// BERR     | berr_n asserted until the strobe is released
module bus_region_decoder
  import bus_decode_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int N_REGIONS   = 16,
  parameter int WAIT_W      = 3,
  parameter int BERR_CYCLES = 64,
  parameter int IDX_W       = $clog2(N_REGIONS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cfg_we,
  input  logic [IDX_W-1:0]     i_cfg_idx,
  input  logic                 i_cfg_en,
  input  logic [ADDR_W-1:0]    i_cfg_start,
  input  logic [ADDR_W-1:0]    i_cfg_end,
  input  logic [WAIT_W-1:0]    i_cfg_wait,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic                 i_as_n,
  output logic [N_REGIONS-1:0] o_cs,
  output logic [IDX_W-1:0]     o_hit_idx,
  output logic                 o_hit,
  output logic                 o_dtack_n,
  output logic                 o_berr_n
);

  localparam int BERR_W = $clog2(BERR_CYCLES + 1);

  region_t                 r_table [N_REGIONS];
  bus_state_e              r_state;
  logic                    r_as_n;
  logic [N_REGIONS-1:0]    r_cs;
  logic                    r_hit;
  logic [IDX_W-1:0]        r_hit_idx;
  logic [RGN_WAIT_MAX-1:0] r_wait_cnt;
  logic [BERR_W-1:0]       r_berr_cnt;

  bus_state_e              w_state_nxt;
  logic [N_REGIONS-1:0]    w_cs_nxt;
  logic                    w_hit_nxt;
  logic [IDX_W-1:0]        w_hit_idx_nxt;
  logic [RGN_WAIT_MAX-1:0] w_wait_cnt_nxt;
  logic [BERR_W-1:0]       w_berr_cnt_nxt;

  logic                    w_match_hit;
  logic [IDX_W-1:0]        w_match_idx;
  logic [N_REGIONS-1:0]    w_match_cs;
  logic [RGN_WAIT_MAX-1:0] w_match_wait;

  // Region table. A write lands on the same edge a DECODE latches, so that
  // decode still sees the previous contents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        r_table[i] <= REGION_CLEAR;
      end
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (i_cfg_we && (i_cfg_idx == IDX_W'(i))) begin
          r_table[i] <= '{en:        i_cfg_en,
                          rgn_start: RGN_ADDR_MAX'(i_cfg_start),
                          rgn_end:   RGN_ADDR_MAX'(i_cfg_end),
                          rgn_wait:  RGN_WAIT_MAX'(i_cfg_wait)};
        end
      end
    end
  end

  region_match #(
    .ADDR_W   (ADDR_W),
    .N_REGIONS(N_REGIONS),
    .IDX_W    (IDX_W)
  ) u_match (
    .i_addr   (i_addr),
    .i_table  (r_table),
    .o_hit    (w_match_hit),
    .o_hit_idx(w_match_idx),
    .o_onehot (w_match_cs)
  );

  assign w_match_wait = r_table[w_match_idx].rgn_wait;

  // The strobe is registered once; the FSM reacts to this sampled copy, which
  // puts the DECODE entry one edge after the strobe is first seen low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_as_n     <= 1'b1;
      r_state    <= ST_IDLE;
      r_cs       <= '0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_wait_cnt <= '0;
      r_berr_cnt <= '0;
    end else begin
      r_as_n     <= i_as_n;
      r_state    <= w_state_nxt;
      r_cs       <= w_cs_nxt;
      r_hit      <= w_hit_nxt;
      r_hit_idx  <= w_hit_idx_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_berr_cnt <= w_berr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cs_nxt       = r_cs;
    w_hit_nxt      = r_hit;
    w_hit_idx_nxt  = r_hit_idx;
    w_wait_cnt_nxt = r_wait_cnt;
    w_berr_cnt_nxt = r_berr_cnt;

    if (r_state == ST_IDLE) begin
      if (!r_as_n) begin
        w_state_nxt = ST_DECODE;
      end
    end else if (r_as_n) begin
      // Strobe released (or cycle aborted): drop everything back to idle.
      w_state_nxt    = ST_IDLE;
      w_cs_nxt       = '0;
      w_hit_nxt      = 1'b0;
      w_hit_idx_nxt  = '0;
      w_wait_cnt_nxt = '0;
      w_berr_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        ST_DECODE: begin
          w_cs_nxt      = w_match_cs;
          w_hit_nxt     = w_match_hit;
          w_hit_idx_nxt = w_match_idx;
          if (w_match_hit) begin
            // Counter is preloaded one short so ACK lands exactly 'wait' edges
            // after the decode edge; zero wait acknowledges alongside cs.
            if (w_match_wait == '0) begin
              w_state_nxt = ST_ACK;
            end else begin
              w_state_nxt    = ST_WAIT;
              w_wait_cnt_nxt = w_match_wait - 1'b1;
            end
          end else begin
            w_state_nxt    = ST_BERR_CNT;
            w_berr_cnt_nxt = BERR_W'(BERR_CYCLES - 1);
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - 1'b1;
          end
        end
        ST_BERR_CNT: begin
          if (r_berr_cnt == '0) begin
            w_state_nxt = ST_BERR;
          end else begin
            w_berr_cnt_nxt = r_berr_cnt - 1'b1;
          end
        end
        ST_ACK, ST_BERR: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_cs      = r_cs;
  assign o_hit     = r_hit;
  assign o_hit_idx = r_hit_idx;
  assign o_dtack_n = (r_state != ST_ACK);
  assign o_berr_n  = (r_state != ST_BERR);

endmodule

// File: tb/tb_bus_region_decoder.sv
module tb_bus_region_decoder;

  localparam int ADDR_W      = 24;
  localparam int N_REGIONS   = 16;
  localparam int WAIT_W      = 3;
  localparam int BERR_CYCLES = 64;
  localparam int IDX_W       = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic                 cfg_en;
  logic [ADDR_W-1:0]    cfg_start;
  logic [ADDR_W-1:0]    cfg_end;
  logic [WAIT_W-1:0]    cfg_wait;
  logic [ADDR_W-1:0]    addr;
  logic                 as_n;
  logic [N_REGIONS-1:0] cs;
  logic [IDX_W-1:0]     hit_idx;
  logic                 hit;
  logic                 dtack_n;
  logic                 berr_n;

  int checks = 0;
  int errors = 0;

  bus_region_decoder #(
    .ADDR_W     (ADDR_W),
    .N_REGIONS  (N_REGIONS),
    .WAIT_W     (WAIT_W),
    .BERR_CYCLES(BERR_CYCLES),
    .IDX_W      (IDX_W)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cfg_we   (cfg_we),
    .i_cfg_idx  (cfg_idx),
    .i_cfg_en   (cfg_en),
    .i_cfg_start(cfg_start),
    .i_cfg_end  (cfg_end),
    .i_cfg_wait (cfg_wait),
    .i_addr     (addr),
    .i_as_n     (as_n),
    .o_cs       (cs),
    .o_hit_idx  (hit_idx),
    .o_hit      (hit),
    .o_dtack_n  (dtack_n),
    .o_berr_n   (berr_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Priority / boundary vectors: address, expected cs, expected hit_idx.
  logic [ADDR_W-1:0]    va   [11] = '{24'h044004, 24'h04400A, 24'h044007, 24'h044008, 24'h04400F,
                                     24'h044010, 24'h040FFF, 24'h041000, 24'h01FFFF, 24'h060010,
                                     24'h06000F};
  logic [N_REGIONS-1:0] vcs  [11] = '{16'h0002, 16'h0020, 16'h0002, 16'h0020, 16'h0020,
                                     16'h0000, 16'h0004, 16'h0000, 16'h0001, 16'h0000,
                                     16'h0000};
  logic [IDX_W-1:0]     vidx [11] = '{4'd1, 4'd5, 4'd1, 4'd5, 4'd5, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic en,
                           input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                           input logic [WAIT_W-1:0] w);
    cfg_idx = idx; cfg_en = en; cfg_start = s; cfg_end = e; cfg_wait = w;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  // Strobe high: sampled on the first edge, outputs cleared on the second.
  task automatic release_bus();
    as_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    as_n  = 1'b0;
    step();
    step();
    checks++;
    if (cs !== 16'h0 || hit !== 1'b0 || hit_idx !== 4'd0 || dtack_n !== 1'b1 || berr_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: cs=%h hit=%b idx=%0d dtack_n=%b berr_n=%b, expected 0000 0 0 1 1",
               cs, hit, hit_idx, dtack_n, berr_n);
    end
    reset = 1'b0;
    as_n  = 1'b1;
    step();
    step();
  endtask

  task automatic test_basic_wait();
    cfg_write(4'd0, 1'b1, 24'h000000, 24'h01FFFF, 3'd0);
    cfg_write(4'd2, 1'b1, 24'h040000, 24'h040FFF, 3'd3);
    addr = 24'h040010;
    as_n = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      step();
      checks++;
      if (e < 2) begin
        if (cs !== 16'h0 || hit !== 1'b0) begin
          errors++;
          $display("FAIL basic_pre_decode edge%0d: cs=%h hit=%b, expected 0000 0", e, cs, hit);
        end
      end else if (cs !== 16'h0004 || hit !== 1'b1 || hit_idx !== 4'd2) begin
        errors++;
        $display("FAIL basic_cs edge%0d: cs=%h hit=%b idx=%0d, expected 0004 1 2", e, cs, hit, hit_idx);
      end
      checks++;
      if (dtack_n !== ((e < 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL basic_dtack edge%0d: dtack_n=%b, expected %b", e, dtack_n, (e < 5) ? 1'b1 : 1'b0);
      end
    end
    as_n = 1'b1;
    step();
    checks++;
    if (dtack_n !== 1'b0 || cs !== 16'h0004) begin
      errors++;
      $display("FAIL basic_hold_on_sample: dtack_n=%b cs=%h, expected 0 0004", dtack_n, cs);
    end
    step();
    checks++;
    if (cs !== 16'h0 || hit !== 1'b0 || hit_idx !== 4'd0 || dtack_n !== 1'b1 || berr_n !== 1'b1) begin
      errors++;
      $display("FAIL basic_clear: cs=%h hit=%b idx=%0d dtack_n=%b berr_n=%b, expected 0000 0 0 1 1",
               cs, hit, hit_idx, dtack_n, berr_n);
    end
  endtask

  task automatic test_back_to_back();
    addr = 24'h000010;
    as_n = 1'b0;
    step(); step(); step();
    checks++;
    if (cs !== 16'h0001 || dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: cs=%h dtack_n=%b, expected 0001 0", cs, dtack_n);
    end
    release_bus();
    addr = 24'h040010;
    as_n = 1'b0;
    step(); step(); step();
    checks++;
    if (cs !== 16'h0004 || hit_idx !== 4'd2 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_decode: cs=%h idx=%0d dtack_n=%b, expected 0004 2 1", cs, hit_idx, dtack_n);
    end
    step(); step(); step();
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_dtack: dtack_n=%b, expected 0", dtack_n);
    end
    release_bus();
  endtask

  task automatic test_priority_bounds();
    cfg_write(4'd1, 1'b1, 24'h044000, 24'h044007, 3'd0);
    cfg_write(4'd5, 1'b1, 24'h044000, 24'h04400F, 3'd0);
    cfg_write(4'd6, 1'b1, 24'h060010, 24'h06000F, 3'd0);
    for (int v = 0; v < 11; v++) begin
      addr = va[v];
      as_n = 1'b0;
      step(); step(); step();
      checks++;
      if (cs !== vcs[v] || hit !== (vcs[v] != 16'h0) || hit_idx !== vidx[v]) begin
        errors++;
        $display("FAIL priority addr=%h: cs=%h hit=%b idx=%0d, expected %h %b %0d",
                 va[v], cs, hit, hit_idx, vcs[v], (vcs[v] != 16'h0), vidx[v]);
      end
      release_bus();
    end
  endtask

  task automatic test_unmapped();
    logic exp_berr;
    addr = 24'h070000;
    as_n = 1'b0;
    for (int e = 0; e <= 66; e++) begin
      step();
      exp_berr = (e < 66) ? 1'b1 : 1'b0;
      checks++;
      if (cs !== 16'h0 || hit !== 1'b0 || dtack_n !== 1'b1 || berr_n !== exp_berr) begin
        errors++;
        $display("FAIL unmapped edge%0d: cs=%h hit=%b dtack_n=%b berr_n=%b, expected 0000 0 1 %b",
                 e, cs, hit, dtack_n, berr_n, exp_berr);
      end
    end
    release_bus();
    checks++;
    if (berr_n !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_clear: berr_n=%b, expected 1", berr_n);
    end
  endtask

  task automatic test_abort();
    cfg_write(4'd3, 1'b1, 24'h050000, 24'h0500FF, 3'd7);
    addr = 24'h050020;
    as_n = 1'b0;
    step(); step(); step(); step();
    as_n = 1'b1;
    step();
    checks++;
    if (cs !== 16'h0008 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL abort_edge4: cs=%h dtack_n=%b, expected 0008 1", cs, dtack_n);
    end
    step();
    checks++;
    if (cs !== 16'h0 || hit !== 1'b0 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle_edge5: cs=%h hit=%b dtack_n=%b, expected 0000 0 1", cs, hit, dtack_n);
    end
    for (int e = 6; e <= 11; e++) begin
      step();
      checks++;
      if (dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL abort_no_dtack edge%0d: dtack_n=%b, expected 1", e, dtack_n);
      end
    end
    addr = 24'h000100;
    as_n = 1'b0;
    step(); step(); step();
    checks++;
    if (cs !== 16'h0001 || dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_cycle: cs=%h dtack_n=%b, expected 0001 0", cs, dtack_n);
    end
    release_bus();
  endtask

  task automatic test_write_same_edge();
    addr = 24'h048000;
    as_n = 1'b0;
    step(); step();
    cfg_write(4'd4, 1'b1, 24'h048000, 24'h0480FF, 3'd0);
    checks++;
    if (cs !== 16'h0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_old_entry: cs=%h hit=%b, expected 0000 0", cs, hit);
    end
    release_bus();
    as_n = 1'b0;
    step(); step(); step();
    checks++;
    if (cs !== 16'h0010 || hit_idx !== 4'd4 || dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_new_entry: cs=%h idx=%0d dtack_n=%b, expected 0010 4 0", cs, hit_idx, dtack_n);
    end
    release_bus();
  endtask

  task automatic test_midcycle_write();
    logic exp_berr;
    addr = 24'h040010;
    as_n = 1'b0;
    step(); step(); step();
    cfg_write(4'd2, 1'b0, 24'h040000, 24'h040FFF, 3'd3);
    addr = 24'h000000;
    step(); step();
    checks++;
    if (cs !== 16'h0004 || hit_idx !== 4'd2 || dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_completes: cs=%h idx=%0d dtack_n=%b, expected 0004 2 0", cs, hit_idx, dtack_n);
    end
    release_bus();
    addr = 24'h040010;
    as_n = 1'b0;
    for (int e = 0; e <= 66; e++) begin
      step();
      exp_berr = (e < 66) ? 1'b1 : 1'b0;
      checks++;
      if (cs !== 16'h0 || dtack_n !== 1'b1 || berr_n !== exp_berr) begin
        errors++;
        $display("FAIL midwrite_next_berr edge%0d: cs=%h dtack_n=%b berr_n=%b, expected 0000 1 %b",
                 e, cs, dtack_n, berr_n, exp_berr);
      end
    end
    release_bus();
  endtask

  task automatic test_reset_in_ack();
    logic exp_berr;
    addr = 24'h000000;
    as_n = 1'b0;
    step(); step(); step();
    checks++;
    if (dtack_n !== 1'b0 || cs !== 16'h0001) begin
      errors++;
      $display("FAIL rst_ack_setup: dtack_n=%b cs=%h, expected 0 0001", dtack_n, cs);
    end
    reset = 1'b1;
    step();
    checks++;
    if (cs !== 16'h0 || hit !== 1'b0 || hit_idx !== 4'd0 || dtack_n !== 1'b1 || berr_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_ack_outputs: cs=%h hit=%b idx=%0d dtack_n=%b berr_n=%b, expected 0000 0 0 1 1",
               cs, hit, hit_idx, dtack_n, berr_n);
    end
    reset = 1'b0;
    release_bus();
    addr = 24'h000000;
    as_n = 1'b0;
    for (int e = 0; e <= 66; e++) begin
      step();
      exp_berr = (e < 66) ? 1'b1 : 1'b0;
      checks++;
      if (cs !== 16'h0 || dtack_n !== 1'b1 || berr_n !== exp_berr) begin
        errors++;
        $display("FAIL rst_table_cleared edge%0d: cs=%h dtack_n=%b berr_n=%b, expected 0000 1 %b",
                 e, cs, dtack_n, berr_n, exp_berr);
      end
    end
    release_bus();
  endtask

  initial begin
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_en    = 1'b0;
    cfg_start = '0;
    cfg_end   = '0;
    cfg_wait  = '0;
    addr      = '0;
    as_n      = 1'b1;

    test_reset();
    test_basic_wait();
    test_back_to_back();
    test_priority_bounds();
    test_unmapped();
    test_abort();
    test_write_same_edge();
    test_midcycle_write();
    test_reset_in_ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_region_decoder.md
# bus_region_decoder

Parametrised, table-driven bus decoder with a per-region wait-state and acknowledge engine for the 68000 (and, with `ADDR_W=16`, the Z80) side of the core. It replaces fixed per-PCB address compares with a runtime-loadable region table. The table is written once per PCB profile by the loader/top level. The block then registers the winning chip select for each bus cycle and generates `dtack_n`/`berr_n` with configurable latency.

## Interface
- `ADDR_W`, 24: compared address width.
- `N_REGIONS`, 16: number of table entries; chip-select vector width.
- `WAIT_W`, 3: width of the per-region wait-state count.
- `BERR_CYCLES`, 64: cycles from decode to `berr_n` on an unmapped access; must be at least 1.
- `IDX_W`, `$clog2(N_REGIONS)`: table index width (derived).
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `cfg_we` in 1: table write strobe.
- `cfg_idx` in IDX_W: entry being written.
- `cfg_en` in 1: entry enable.
- `cfg_start` in ADDR_W: inclusive start address.
- `cfg_end` in ADDR_W: inclusive end address.
- `cfg_wait` in WAIT_W: wait states before acknowledge.
- `addr` in ADDR_W: bus address.
- `as_n` in 1: address strobe, active-low (on the Z80 instance: `MREQ_n`).
- `cs` out N_REGIONS: registered one-hot chip selects.
- `hit_idx` out IDX_W: index of the active region.
- `hit` out 1: a region is selected.
- `dtack_n` out 1: acknowledge, active-low.
- `berr_n` out 1: bus error, active-low.

## Operation
- Table entry `i` matches when `en[i]` is set and `start[i] <= addr <= end[i]`. The compare is unsigned and uses the full `ADDR_W` bits. An entry with `start > end` never matches.
- Priority: the lowest matching index wins. `cs` is always zero-hot or one-hot.
- FSM states:
  - IDLE: `as_n` sampled low moves to DECODE.
  - DECODE: latch `addr` compare result, `hit_idx` and wait count; go to WAIT if hit, else to BERR_CNT.
  - WAIT: count down; at 0 go to ACK.
  - ACK: `dtack_n` low; stay until `as_n` high.
  - BERR_CNT: count `BERR_CYCLES`, then go to BERR.
  - BERR: `berr_n` low; stay until `as_n` high.
- `as_n` sampled high in any non-IDLE state returns the FSM to IDLE. This aborts a cycle in progress, including during WAIT or BERR_CNT.
- The decode result is frozen for the whole cycle. `addr` changes and table writes during an active cycle do not alter `cs`.
- Table writes take effect for decodes starting on the next clock edge. A write and a decode in the same cycle use the old entry.
- Reset clears all entries (`en=0`, `start=end=0`, `wait=0`).

## Timing
- Reset values: `cs=0`, `hit=0`, `hit_idx=0`, `dtack_n=1`, `berr_n=1`, state IDLE.
- Edge 0 samples `as_n` low; the FSM enters DECODE at edge 1.
- `cs`, `hit` and `hit_idx` are valid from edge 2 and held until `as_n` is sampled high.
- `dtack_n` falls at edge `2 + wait`. With `wait=0`, it falls in the same cycle `cs` rises.
- `berr_n` falls at edge `2 + BERR_CYCLES`; `cs` stays 0 throughout.
- At the edge after `as_n` is sampled high, all outputs return to reset values.
- Back-to-back cycles: `as_n` low again one cycle after IDLE re-entry decodes normally. The minimum turnaround is one IDLE cycle.
- The wait counter is `WAIT_W` bits and does not wrap: the maximum is `2^WAIT_W-1`.
- The BERR counter saturates at `BERR_CYCLES`.

## Structure
- Shared package `bus_decode_pkg`:
  - FSM state enum (IDLE, DECODE, WAIT, ACK, BERR_CNT, BERR).
  - Region record typedef (`en`, `start`, `end`, `wait`).
  - PCB profile index constants: terra_cresta=0, amazon=1, horekid=2, amazont=3, horekidb2=4.
- One sub-module, `region_match`. It is purely combinational: a priority encoder over `N_REGIONS` compares that outputs `hit`, `hit_idx` and the one-hot vector.
- The table registers, FSM and counters stay in the top module.

## Test plan
- Load entry 0 = 000000–01FFFF with wait 0, and entry 2 = 040000–040FFF with wait 3. Drive `addr=040010` with `as_n` low at edge 0:
  - `cs=0x0004` and `hit_idx=2` at edge 2.
  - `dtack_n` low at edge 5.
  - All outputs clear one edge after `as_n` goes high.
- Overlap: entry 1 = 044000–044007 and entry 5 = 044000–04400F. Drive `addr=044004`:
  - `cs=0x0002`.
  - `addr=04400A` gives `cs=0x0020`.
- Unmapped `addr=070000` with `BERR_CYCLES=64`:
  - `cs=0` throughout.
  - `berr_n` low at edge 66; `dtack_n` stays 1.
- Abort: wait=7, release `as_n` at edge 4:
  - `dtack_n` never asserts.
  - FSM returns to IDLE at edge 5.
  - The next cycle decodes normally.
- Table write mid-cycle: rewrite the active entry 2 to disabled during WAIT:
  - Current cycle still completes with `dtack_n`.
  - The next access to `040010` bus-errors.
- Reset during ACK:
  - All outputs return to reset values at the next edge.
  - The table is cleared, so `addr=000000` bus-errors afterwards.
